// File: rtl/fft_peak_detect_if.sv
// fft_peak_detect_if: FFT frame input bus and peak-report outputs.
// master drives frames and observes results; slave is the detector.
interface fft_peak_detect_if;
    logic        fft_valid;
    logic [31:0] fft_d0;
    logic [31:0] fft_d1;
    logic [31:0] fft_d2;
    logic [31:0] fft_d3;
    logic [31:0] fft_d4;
    logic [31:0] fft_d5;
    logic [31:0] fft_d6;
    logic [31:0] fft_d7;
    logic [31:0] fft_d8;
    logic [31:0] fft_d9;
    logic [31:0] fft_d10;
    logic [31:0] fft_d11;
    logic [31:0] fft_d12;
    logic [31:0] fft_d13;
    logic [31:0] fft_d14;
    logic [31:0] fft_d15;
    logic        done;
    logic [3:0]  freq;
    logic [31:0] peak_pwr;
    logic        busy;
    logic        overflow;

    modport master (
        output fft_valid,
        output fft_d0, fft_d1, fft_d2, fft_d3,
        output fft_d4, fft_d5, fft_d6, fft_d7,
        output fft_d8, fft_d9, fft_d10, fft_d11,
        output fft_d12, fft_d13, fft_d14, fft_d15,
        input  done, freq, peak_pwr, busy, overflow
    );

    modport slave (
        input  fft_valid,
        input  fft_d0, fft_d1, fft_d2, fft_d3,
        input  fft_d4, fft_d5, fft_d6, fft_d7,
        input  fft_d8, fft_d9, fft_d10, fft_d11,
        input  fft_d12, fft_d13, fft_d14, fft_d15,
        output done, freq, peak_pwr, busy, overflow
    );
endinterface

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-bin power and strongest-bin search, one bin per cycle.
// Macro FFT_PEAK_HALF_SPECTRUM_EN scans only bins 0-7 (conjugate symmetry).
module fft_peak_detect (
    input  logic             clk,
    input  logic             rst,
    fft_peak_detect_if.slave bus
);
`ifdef FFT_PEAK_HALF_SPECTRUM_EN
    localparam int NB = 8;
`else
    localparam int NB = 16;
`endif
    localparam int         IW   = $clog2(NB);
    localparam logic [3:0] LAST = 4'(NB - 1);

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_work [NB];
    logic [31:0]        r_pend [NB];
    logic               r_pend_v;
    logic [3:0]         r_cnt;
    logic [31:0]        r_max_pwr;
    logic [3:0]         r_max_idx;
    logic               r_done;
    logic [3:0]         r_freq;
    logic [31:0]        r_peak;
    logic               r_ovf;

    logic [31:0]        w_in [NB];
    logic               w_last;
    logic               w_load_in;
    logic               w_load_pend;
    logic               w_wr_pend;
    logic               w_pend_v_nxt;
    logic               w_ovf_set;
    logic [31:0]        w_bin;
    logic signed [15:0] w_re;
    logic signed [15:0] w_im;
    logic signed [31:0] w_sq_re;
    logic signed [31:0] w_sq_im;
    logic [31:0]        w_pwr;
    logic               w_gt;
    logic [31:0]        w_max_nxt;
    logic [3:0]         w_idx_nxt;

    assign w_in[0] = bus.fft_d0;
    assign w_in[1] = bus.fft_d1;
    assign w_in[2] = bus.fft_d2;
    assign w_in[3] = bus.fft_d3;
    assign w_in[4] = bus.fft_d4;
    assign w_in[5] = bus.fft_d5;
    assign w_in[6] = bus.fft_d6;
    assign w_in[7] = bus.fft_d7;
`ifndef FFT_PEAK_HALF_SPECTRUM_EN
    assign w_in[8]  = bus.fft_d8;
    assign w_in[9]  = bus.fft_d9;
    assign w_in[10] = bus.fft_d10;
    assign w_in[11] = bus.fft_d11;
    assign w_in[12] = bus.fft_d12;
    assign w_in[13] = bus.fft_d13;
    assign w_in[14] = bus.fft_d14;
    assign w_in[15] = bus.fft_d15;
`endif

    assign w_last = (r_state == S_SCAN) && (r_cnt == LAST);

    // Power of the bin under scan; the sum peaks at exactly 2^31, so it fits unsigned 32
    assign w_bin   = r_work[r_cnt[IW-1:0]];
    assign w_re    = w_bin[31:16];
    assign w_im    = w_bin[15:0];
    assign w_sq_re = 32'(w_re) * 32'(w_re);
    assign w_sq_im = 32'(w_im) * 32'(w_im);
    assign w_pwr   = w_sq_re + w_sq_im;

    // Bin 0 seeds the running max; later bins replace it only when strictly larger
    assign w_gt      = (r_cnt == 4'd0) || (w_pwr > r_max_pwr);
    assign w_max_nxt = w_gt ? w_pwr : r_max_pwr;
    assign w_idx_nxt = w_gt ? r_cnt : r_max_idx;

    // Next state and frame routing between input, pending and working buffers
    always_comb begin
        w_state_nxt  = r_state;
        w_load_in    = 1'b0;
        w_load_pend  = 1'b0;
        w_wr_pend    = 1'b0;
        w_pend_v_nxt = r_pend_v;
        w_ovf_set    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.fft_valid) begin
                    w_state_nxt = S_SCAN;
                    w_load_in   = 1'b1;
                end
            end
            S_SCAN: begin
                if (w_last) begin
                    if (r_pend_v) begin
                        w_load_pend  = 1'b1;
                        w_wr_pend    = bus.fft_valid;
                        w_pend_v_nxt = bus.fft_valid;
                    end else if (bus.fft_valid) begin
                        w_load_in = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (bus.fft_valid) begin
                    w_wr_pend    = 1'b1;
                    w_pend_v_nxt = 1'b1;
                    w_ovf_set    = r_pend_v;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control state, scan counter, running max and registered results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pend_v  <= 1'b0;
            r_cnt     <= 4'd0;
            r_max_pwr <= 32'd0;
            r_max_idx <= 4'd0;
            r_done    <= 1'b0;
            r_freq    <= 4'd0;
            r_peak    <= 32'd0;
            r_ovf     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pend_v <= w_pend_v_nxt;
            r_done   <= w_last;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_load_in || w_load_pend) begin
                r_cnt     <= 4'd0;
                r_max_pwr <= 32'd0;
                r_max_idx <= 4'd0;
            end else if (r_state == S_SCAN) begin
                r_cnt     <= r_cnt + 4'd1;
                r_max_pwr <= w_max_nxt;
                r_max_idx <= w_idx_nxt;
            end
            if (w_last) begin
                r_freq <= w_idx_nxt;
                r_peak <= w_max_nxt;
            end
        end
    end

    // Frame buffers carry no reset; their contents matter only while scanning
    always_ff @(posedge clk) begin
        if (w_load_in) begin
            r_work <= w_in;
        end else if (w_load_pend) begin
            r_work <= r_pend;
        end
        if (w_wr_pend) begin
            r_pend <= w_in;
        end
    end

    assign bus.done     = r_done;
    assign bus.freq     = r_freq;
    assign bus.peak_pwr = r_peak;
    assign bus.busy     = (r_state == S_SCAN);
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: frame-level reference model plus directed and random frames.
// The model reasons in whole frames and scan ages, not in RTL state.
module tb_fft_peak_detect;
`ifdef FFT_PEAK_HALF_SPECTRUM_EN
    localparam int NB = 8;
`else
    localparam int NB = 16;
`endif

    typedef logic [31:0] frame_t [16];

    logic clk = 1'b0;
    logic rst = 1'b1;

    fft_peak_detect_if bus ();

    fft_peak_detect dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    bit chk_en  = 1'b0;
    int last_valid_cyc = 0;

    bit          m_busy   = 1'b0;
    bit          m_done   = 1'b0;
    bit          m_ovf    = 1'b0;
    bit          m_pend_v = 1'b0;
    int          m_age    = 0;
    logic [3:0]  m_freq   = 4'd0;
    logic [31:0] m_pwr    = 32'd0;
    frame_t      m_work;
    frame_t      m_pend;

    int          ev_cyc[$];
    int          ev_freq[$];
    longint      ev_pwr[$];

    // Strongest bin by plain integer arithmetic; first maximum wins
    task automatic peak(input frame_t f, output logic [3:0] idx,
                        output logic [31:0] pwr);
        longint  best;
        longint  p;
        shortint re;
        shortint im;
        best = -1;
        idx  = 4'd0;
        for (int k = 0; k < NB; k++) begin
            re = f[k][31:16];
            im = f[k][15:0];
            p  = longint'(re) * re + longint'(im) * im;
            if (p > best) begin
                best = p;
                idx  = 4'(k);
            end
        end
        pwr = 32'(best);
    endtask

    task automatic read_in(output frame_t f);
        f[0]  = bus.fft_d0;  f[1]  = bus.fft_d1;
        f[2]  = bus.fft_d2;  f[3]  = bus.fft_d3;
        f[4]  = bus.fft_d4;  f[5]  = bus.fft_d5;
        f[6]  = bus.fft_d6;  f[7]  = bus.fft_d7;
        f[8]  = bus.fft_d8;  f[9]  = bus.fft_d9;
        f[10] = bus.fft_d10; f[11] = bus.fft_d11;
        f[12] = bus.fft_d12; f[13] = bus.fft_d13;
        f[14] = bus.fft_d14; f[15] = bus.fft_d15;
    endtask

    // Reference model: a frame started at edge t reports at edge t+NB
    always @(posedge clk or negedge rst) begin
        frame_t fin;
        if (!rst) begin
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_ovf    = 1'b0;
            m_pend_v = 1'b0;
            m_age    = 0;
            m_freq   = 4'd0;
            m_pwr    = 32'd0;
        end else begin
            cycle++;
            m_done = 1'b0;
            read_in(fin);
            if (m_busy) begin
                m_age++;
                if (m_age == NB) begin
                    m_done = 1'b1;
                    peak(m_work, m_freq, m_pwr);
                    if (m_pend_v) begin
                        m_work = m_pend;
                        m_age  = 0;
                        if (bus.fft_valid) m_pend = fin;
                        else m_pend_v = 1'b0;
                    end else if (bus.fft_valid) begin
                        m_work = fin;
                        m_age  = 0;
                    end else begin
                        m_busy = 1'b0;
                    end
                end else if (bus.fft_valid) begin
                    if (m_pend_v) m_ovf = 1'b1;
                    m_pend   = fin;
                    m_pend_v = 1'b1;
                end
            end else if (bus.fft_valid) begin
                m_busy = 1'b1;
                m_work = fin;
                m_age  = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (bus.done !== m_done || bus.freq !== m_freq ||
                bus.peak_pwr !== m_pwr || bus.busy !== m_busy ||
                bus.overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL cycle %0d outputs: got done=%b freq=%0d pwr=%h busy=%b ovf=%b, want done=%b freq=%0d pwr=%h busy=%b ovf=%b",
                         cycle, bus.done, bus.freq, bus.peak_pwr, bus.busy,
                         bus.overflow, m_done, m_freq, m_pwr, m_busy, m_ovf);
            end
            if (bus.done === 1'b1) begin
                ev_cyc.push_back(cycle);
                ev_freq.push_back(int'(bus.freq));
                ev_pwr.push_back(longint'(bus.peak_pwr));
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit v, input frame_t f);
        bus.fft_valid = v;
        bus.fft_d0  = f[0];  bus.fft_d1  = f[1];
        bus.fft_d2  = f[2];  bus.fft_d3  = f[3];
        bus.fft_d4  = f[4];  bus.fft_d5  = f[5];
        bus.fft_d6  = f[6];  bus.fft_d7  = f[7];
        bus.fft_d8  = f[8];  bus.fft_d9  = f[9];
        bus.fft_d10 = f[10]; bus.fft_d11 = f[11];
        bus.fft_d12 = f[12]; bus.fft_d13 = f[13];
        bus.fft_d14 = f[14]; bus.fft_d15 = f[15];
    endtask

    task automatic garbage(output frame_t f);
        for (int k = 0; k < 16; k++) f[k] = $urandom;
    endtask

    task automatic rand_frame(output frame_t f);
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 5))
                0: f[k] = 32'd0;
                1: f[k] = $urandom;
                2: f[k] = {16'($urandom_range(0, 64) - 32),
                           16'($urandom_range(0, 64) - 32)};
                3: f[k] = (k > 0) ? f[k-1] : 32'h0001_0000;
                4: f[k] = 32'h8000_8000;
                default: f[k] = {$urandom_range(0, 1) ? 16'h7FFF : 16'h8001,
                                 16'h7FFF};
            endcase
        end
    endtask

    task automatic drive(input bit v, input frame_t f);
        @(negedge clk);
        #1;
        set_in(v, f);
        if (v) last_valid_cyc = cycle + 1;
    endtask

    task automatic idle(input int n);
        frame_t g;
        for (int i = 0; i < n; i++) begin
            garbage(g);
            drive(1'b0, g);
        end
    endtask

    task automatic clear_log();
        ev_cyc.delete();
        ev_freq.delete();
        ev_pwr.delete();
    endtask

    task automatic zero_frame(output frame_t f);
        for (int k = 0; k < 16; k++) f[k] = 32'd0;
    endtask

    // One frame in isolation; pins latency, index and power
    task automatic run_one(input string name, input frame_t f,
                           input int efreq, input longint epwr);
        int t0;
        clear_log();
        drive(1'b1, f);
        t0 = last_valid_cyc;
        idle(NB + 6);
        chk({name, " done count"}, ev_cyc.size(), 1);
        if (ev_cyc.size() == 1) begin
            chk({name, " latency"}, ev_cyc[0] - t0, NB);
            chk({name, " freq"}, ev_freq[0], efreq);
            chk({name, " peak_pwr"}, ev_pwr[0], epwr);
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, " done"}, bus.done, 0);
        chk({name, " freq"}, bus.freq, 0);
        chk({name, " peak_pwr"}, bus.peak_pwr, 0);
        chk({name, " busy"}, bus.busy, 0);
        chk({name, " overflow"}, bus.overflow, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        frame_t g;
        int     t0;
        zero_frame(f);
        #1 rst = 1'b0;
        set_in(1'b0, f);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        #3 rst = 1'b1;
        idle(2);

        zero_frame(f);
        f[5] = 32'h0100_0000;
        run_one("tone", f, 5, 64'h0001_0000);

`ifndef FFT_PEAK_HALF_SPECTRUM_EN
        zero_frame(f);
        f[3] = 32'hFF00_0000;
        f[9] = 32'h0100_0000;
        run_one("tie", f, 3, 64'h0001_0000);

        zero_frame(f);
        f[12] = 32'h8000_8000;
        f[1]  = 32'h7FFF_7FFF;
        run_one("extreme", f, 12, 64'h8000_0000);

        clear_log();
        for (int i = 0; i < 4; i++) begin
            zero_frame(f);
            f[i+1] = 32'h0010_0000;
            drive(1'b1, f);
            if (i == 0) t0 = last_valid_cyc;
            if (i == 3) chk("sustained busy", bus.busy, 1);
            idle(15);
        end
        idle(20);
        chk("sustained done count", ev_cyc.size(), 4);
        if (ev_cyc.size() == 4) begin
            chk("sustained first latency", ev_cyc[0] - t0, 16);
            for (int i = 0; i < 4; i++) begin
                chk("sustained freq", ev_freq[i], i + 1);
                if (i > 0) chk("sustained spacing", ev_cyc[i] - ev_cyc[i-1], 16);
            end
        end
        chk("sustained overflow", bus.overflow, 0);

        clear_log();
        for (int i = 0; i < 3; i++) begin
            zero_frame(f);
            f[6+i] = 32'h0000_0300;
            drive(1'b1, f);
            if (i < 2) begin
                garbage(g);
                drive(1'b0, g);
            end
        end
        idle(45);
        chk("overflow done count", ev_cyc.size(), 2);
        if (ev_cyc.size() == 2) begin
            chk("overflow freq a", ev_freq[0], 6);
            chk("overflow freq b", ev_freq[1], 8);
            chk("overflow spacing", ev_cyc[1] - ev_cyc[0], 16);
        end
        chk("overflow flag", bus.overflow, 1);
`endif

        zero_frame(f);
        f[2] = 32'h0040_0040;
        drive(1'b1, f);
        idle(5);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_zero_outputs("mid reset");
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        clear_log();
        idle(NB + 8);
        chk("mid reset no done", ev_cyc.size(), 0);
        zero_frame(f);
        f[4] = 32'hFFF0_0020;
        run_one("after reset", f, 4, 64'h0000_0500);

        for (int n = 0; n < 70; n++) begin
            idle($urandom_range(0, 20));
            rand_frame(f);
            drive(1'b1, f);
            if (n == 40) begin
                idle($urandom_range(1, 12));
                @(posedge clk);
                #3 rst = 1'b0;
                @(negedge clk);
                #3 rst = 1'b1;
            end
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
